// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters; one transaction in flight.
// Accept at edge N, response valid from N+2; response held until resp ready, requests stalled meanwhile.
module alu_arbiter #(
   parameter int bit_size = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [3:0]          req0_op,
   input  logic [bit_size-1:0] req0_src1,
   input  logic [bit_size-1:0] req0_src2,
   input  logic [4:0]          req0_shamt,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic [3:0]          req1_op,
   input  logic [bit_size-1:0] req1_src1,
   input  logic [bit_size-1:0] req1_src2,
   input  logic [4:0]          req1_shamt,
   output logic                resp0_valid,
   input  logic                resp0_ready,
   output logic [bit_size-1:0] resp0_result,
   output logic                resp0_zero,
   output logic                resp1_valid,
   input  logic                resp1_ready,
   output logic [bit_size-1:0] resp1_result,
   output logic                resp1_zero,
   output logic [3:0]          alu_op,
   output logic [bit_size-1:0] alu_src1,
   output logic [bit_size-1:0] alu_src2,
   output logic [4:0]          alu_shamt,
   input  logic [bit_size-1:0] alu_result,
   input  logic                alu_zero,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t              state, state_nxt;
   logic                last_grant;
   logic                owner;
   logic [3:0]          op_q;
   logic [bit_size-1:0] src1_q, src2_q, res_q;
   logic [4:0]          shamt_q;
   logic                zero_q;

   logic                any_req;
   logic                grant;
   logic                accept;

   assign any_req = req0_valid | req1_valid;
   // On a tie the port that did not win last time goes next.
   assign grant   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
   assign accept  = (state == IDLE) && any_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      resp0_valid  = 1'b0;
      resp1_valid  = 1'b0;
      resp0_result = '0;
      resp1_result = '0;
      resp0_zero   = 1'b0;
      resp1_zero   = 1'b0;
      alu_op       = 4'd0;
      alu_src1     = '0;
      alu_src2     = '0;
      alu_shamt    = 5'd0;
      busy         = (state != IDLE);
      case (state)
         IDLE: begin
            req0_ready = accept && !grant;
            req1_ready = accept && grant;
            if (accept) begin
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            alu_op    = op_q;
            alu_src1  = src1_q;
            alu_src2  = src2_q;
            alu_shamt = shamt_q;
            state_nxt = RESP;
         end
         RESP: begin
            if (owner) begin
               resp1_valid  = 1'b1;
               resp1_result = res_q;
               resp1_zero   = zero_q;
               if (resp1_ready) state_nxt = IDLE;
            end else begin
               resp0_valid  = 1'b1;
               resp0_result = res_q;
               resp0_zero   = zero_q;
               if (resp0_ready) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b1;
         owner      <= 1'b0;
         op_q       <= 4'd0;
         src1_q     <= '0;
         src2_q     <= '0;
         shamt_q    <= 5'd0;
         res_q      <= '0;
         zero_q     <= 1'b0;
      end else begin
         if (accept) begin
            owner      <= grant;
            last_grant <= grant;
            op_q       <= grant ? req1_op    : req0_op;
            src1_q     <= grant ? req1_src1  : req0_src1;
            src2_q     <= grant ? req1_src2  : req0_src2;
            shamt_q    <= grant ? req1_shamt : req0_shamt;
         end
         if (state == EXEC) begin
            res_q  <= alu_result;
            zero_q <= alu_zero;
         end
      end
   end

endmodule
